// File: rtl/csr_uart_tx.sv
// csr_uart_tx
//   CSR-mapped 8N1 UART transmitter. Bytes written to BASE_ADDR are queued in a
//   circular FIFO and shifted out LSB first on tx. A status read at BASE_ADDR
//   returns {29'b0, overflow, busy, full}; all-zero means ready.
//
//   Parameters
//     BASE_ADDR  CSR address for data write and status read
//     BAUD_DIV   clk cycles per serial bit (>= 2)
//     FIFO_LOG2  FIFO depth is 2**FIFO_LOG2 bytes (>= 1)
//
//   Ports
//     clk     clock, all state on rising edge
//     rst     asynchronous active-high reset
//     read    CSR read strobe, qualified by the previous cycle's addr
//     modify  CSR modify op (1 = write), qualified by the previous cycle's addr
//     wdata   CSR write data, byte in [7:0]
//     addr    CSR address, presented one cycle ahead of read/modify
//     rdata   registered status, zero when not selected
//     valid   registered, high when this block answers a read
//     tx      registered serial output, idle high
module csr_uart_tx #(
  parameter logic [11:0] BASE_ADDR = 12'hBC0,
  parameter int unsigned BAUD_DIV  = 868,
  parameter int unsigned FIFO_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        tx
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned PW    = FIFO_LOG2 + 1;
  localparam int unsigned CW    = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     idx_q;
  logic [7:0]     shift_q;
  logic           tx_q;
  logic [11:0]    addr_q;
  logic [31:0]    rdata_q;
  logic           valid_q;
  logic           ovf_q, ovf_d;
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [7:0]     mem_q [DEPTH];

  logic        sel, push, rd_hit, pop, push_ok, ovf_set;
  logic        full, empty, busy, bit_end;
  logic [7:0]  head;
  logic [31:0] status;
  logic        unused_wdata;

  // Only the low byte is transmitted.
  assign unused_wdata = ^wdata[31:8];

  always_comb begin
    sel     = (addr_q == BASE_ADDR);
    push    = sel && (modify == 3'd1);
    rd_hit  = sel && read;
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[PW-1] != rptr_q[PW-1]) &&
              (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
    busy    = !empty || (state_q != IDLE);
    bit_end = (cnt_q == CNT_LAST);
    head    = mem_q[rptr_q[PW-2:0]];
    // Pop from IDLE, or at the end of STOP so frames run back to back.
    pop     = !empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    // A pop in the same cycle frees a slot, so a push while full still fits.
    push_ok = push && (!full || pop);
    ovf_set = push && full && !pop;
    wptr_d  = wptr_q + PW'(push_ok);
    rptr_d  = rptr_q + PW'(pop);
    // A fresh overflow wins over the clear caused by a status read.
    ovf_d   = ovf_set ? 1'b1 : (rd_hit ? 1'b0 : ovf_q);
    status  = {29'b0, ovf_q, busy, full};
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[PW-2:0]] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      addr_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      addr_q  <= addr;
      valid_q <= rd_hit;
      rdata_q <= rd_hit ? status : '0;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            cnt_q   <= '0;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 3'd1;
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (pop) begin
              shift_q <= head;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx    = tx_q;
  assign rdata = rdata_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_csr_uart_tx.sv
// tb_csr_uart_tx
//   Randomized and directed stimulus for csr_uart_tx against a behavioural
//   model: a byte queue plus a frame-remaining counter, from which the expected
//   tx level, status word and read response are derived each cycle.
module tb_csr_uart_tx;

  localparam logic [11:0] BASE  = 12'hBC0;
  localparam int unsigned B     = 4;
  localparam int unsigned LOG2  = 3;
  localparam int unsigned DEPTH = 1 << LOG2;
  localparam int unsigned FRAME = 10 * B;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_clk = 1'b0;
  logic        read = 1'b0;
  logic [2:0]  modify = '0;
  logic [31:0] wdata = '0;
  logic [11:0] addr = '0;
  logic [31:0] rdata;
  logic        valid;
  logic        tx;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  csr_uart_tx #(.BASE_ADDR(BASE), .BAUD_DIV(B), .FIFO_LOG2(LOG2)) dut (
    .clk(clk), .rst(rst), .read(read), .modify(modify), .wdata(wdata),
    .addr(addr), .rdata(rdata), .valid(valid), .tx(tx)
  );

  always begin
    #5;
    if (run_clk) clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_q[$];
  int unsigned m_rem = 0;        // cycles of the current frame still to run
  logic [7:0]  m_byte = '0;
  logic        m_ovf = 1'b0;
  logic [11:0] m_qaddr = '0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        m_hit_rd, m_hit_wr, m_set_ovf;

  function automatic logic [31:0] m_status();
    logic full, busy;
    full = (m_q.size() == DEPTH);
    busy = (m_q.size() != 0) || (m_rem != 0);
    return {29'b0, m_ovf, busy, full};
  endfunction

  function automatic logic m_tx();
    int unsigned k;
    logic [7:0] b;
    if (m_rem == 0) return 1'b1;
    k = (FRAME - m_rem) / B;     // 0 start, 1..8 data, 9 stop
    b = m_byte;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_rem = 0;
      m_byte = '0;
      m_ovf = 1'b0;
      m_qaddr = '0;
      exp_valid = 1'b0;
      exp_rdata = '0;
    end else begin
      m_hit_rd  = read && (m_qaddr == BASE);
      m_hit_wr  = (modify == 3'd1) && (m_qaddr == BASE);
      exp_valid = m_hit_rd;
      exp_rdata = m_hit_rd ? m_status() : 32'd0;
      m_set_ovf = 1'b0;
      if (m_rem <= 1 && m_q.size() != 0) begin
        m_byte = m_q.pop_front();
        m_rem  = FRAME;
      end else if (m_rem != 0) begin
        m_rem = m_rem - 1;
      end
      if (m_hit_wr) begin
        if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]);
        else m_set_ovf = 1'b1;
      end
      if (m_set_ovf) m_ovf = 1'b1;
      else if (m_hit_rd) m_ovf = 1'b0;
      m_qaddr = addr;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("tx", tx, m_tx());
      check_eq("valid", valid, exp_valid);
      check_eq("rdata", rdata, exp_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic csr_op(input logic [11:0] a, input logic rd, input logic [2:0] mod, input logic [31:0] wd);
    addr = a;
    tick();
    read = rd;
    modify = mod;
    wdata = wd;
    tick();
    read = 1'b0;
    modify = '0;
  endtask

  task automatic write_burst(input int unsigned n, input logic [7:0] b0, input logic [7:0] b1);
    addr = BASE;
    tick();
    for (int unsigned i = 0; i < n; i++) begin
      modify = 3'd1;
      wdata = (i == 0) ? {24'hFFFFFF, b0} : (i == 1) ? {24'h0, b1} : $urandom;
      tick();
    end
    modify = '0;
  endtask

  task automatic wait_drain(input int unsigned bound);
    logic done;
    done = 1'b0;
    for (int unsigned i = 0; i < bound; i++) begin
      if (m_rem == 0 && m_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check_eq("drain_timeout", done, 1'b1);
  endtask

  initial begin
    logic [39:0] cap, wave;
    logic        seen;
    int unsigned kpos;

    // reset with the clock stopped
    #1 rst = 1'b1;
    #4;
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    #1 run_clk = 1'b1;
    tick();
    csr_op(BASE, 1'b1, 3'd0, 32'd0);
    tick();

    // single 0x55 frame: capture the waveform explicitly
    csr_op(BASE, 1'b0, 3'd1, 32'hDEAD_BE55);
    seen = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (tx == 1'b0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_eq("start_seen", seen, 1'b1);
    cap = '0;
    for (int unsigned i = 0; i < 40; i++) begin
      cap[39-i] = tx;
      tick();
    end
    wave = 40'b0000_1111_0000_1111_0000_1111_0000_1111_0000_1111;
    check_eq("wave_55", cap, wave);
    wait_drain(100);
    csr_op(BASE, 1'b1, 3'd0, 32'd0);
    tick();

    // back-to-back frames
    write_burst(2, 8'hA5, 8'h3C);
    wait_drain(200);
    tick();

    // overflow: 10 writes, then two status reads
    write_burst(10, 8'h11, 8'h22);
    csr_op(BASE, 1'b1, 3'd0, 32'd0);
    csr_op(BASE, 1'b1, 3'd0, 32'd0);
    wait_drain(12 * FRAME);
    tick();

    // decode
    csr_op(12'hBC1, 1'b1, 3'd1, 32'h77);
    csr_op(12'hFC0, 1'b1, 3'd1, 32'h66);
    csr_op(BASE, 1'b0, 3'd2, 32'h55);
    csr_op(BASE, 1'b1, 3'd0, 32'd0);
    repeat (5) tick();

    // reset mid-frame during data bit 3 with 3 bytes queued
    write_burst(4, 8'hF0, 8'h0F);
    seen = 1'b0;
    for (int unsigned i = 0; i < 200; i++) begin
      kpos = (m_rem != 0) ? (FRAME - m_rem) / B : 0;
      if (m_rem != 0 && kpos == 4) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_eq("bit3_reached", seen, 1'b1);
    #2 rst = 1'b1;
    #1 check_eq("midrst_tx", tx, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    csr_op(BASE, 1'b1, 3'd0, 32'd0);
    repeat (2 * FRAME) tick();

    // randomized traffic
    for (int unsigned n = 0; n < 300; n++) begin
      int unsigned sel;
      logic [11:0] a;
      logic [2:0]  m;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        write_burst($urandom_range(1, 10), 8'($urandom), 8'($urandom));
      end else begin
        a = (sel < 7) ? BASE : ((sel == 7) ? 12'hBC1 : 12'($urandom));
        m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
        csr_op(a, 1'($urandom_range(0, 1)), m, $urandom);
      end
      repeat ($urandom_range(0, 20)) tick();
    end
    wait_drain(12 * FRAME);
    csr_op(BASE, 1'b1, 3'd0, 32'd0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
